// File: rtl/rom_dl_router.sv
// Routes the hps_io byte-serial ROM download into the SDRAM loader (through a 2-entry buffer)
// and the on-chip PROMs, tracking completion, dropped bytes and a running checksum.
module rom_dl_router #(
    parameter logic [21:0] PROM_START = 22'h3C000,
    parameter int          PROM_AW    = 8,
    parameter int          PROM_CNT   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                downloading,
    input  logic                ioctl_wr,
    input  logic [24:0]         ioctl_addr,
    input  logic [7:0]          ioctl_data,
    output logic                prog_we,
    output logic [21:0]         prog_addr,
    output logic [7:0]          prog_data,
    output logic [1:0]          prog_mask,
    input  logic                prog_ack,
    output logic [PROM_CNT-1:0] prom_we,
    output logic [PROM_AW-1:0]  prom_addr,
    output logic [7:0]          prom_data,
    output logic                dl_done,
    output logic                overflow,
    output logic [15:0]         checksum
);
    // state | meaning
    // IDLE  | no SDRAM request outstanding
    // ISSUE | request on prog_*, waiting for prog_ack
    // FLUSH | download window closed, draining the buffer before dl_done
    typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;

    localparam logic [24:0] PROM_LO = {3'b000, PROM_START};
    localparam logic [24:0] PROM_HI = PROM_LO + 25'(PROM_CNT << PROM_AW);

    state_t      state;
    logic [31:0] fifo_q [2];
    logic [1:0]  count;
    logic        dl_prev;

    logic        rise, fall, strobe, in_sdram, in_prom, pop, push, drop, flushing, wr_idx;
    logic [1:0]  count_cur, count_nxt;
    logic [24:0] off;
    logic [31:0] entry;

    always_comb begin
        rise      = downloading & ~dl_prev;
        fall      = ~downloading & dl_prev;
        strobe    = ioctl_wr & downloading;
        in_sdram  = ioctl_addr < PROM_LO;
        in_prom   = ~in_sdram & (ioctl_addr < PROM_HI);
        off       = ioctl_addr - PROM_LO;
        // a download start empties the buffer before this cycle's strobe is considered
        count_cur = rise ? 2'd0 : count;
        pop       = prog_we & prog_ack & ~rise;
        push      = strobe & in_sdram & ((count_cur != 2'd2) | pop);
        drop      = strobe & in_sdram & (count_cur == 2'd2) & ~pop;
        wr_idx    = ((count_cur - {1'b0, pop}) == 2'd1);
        count_nxt = count_cur - {1'b0, pop} + {1'b0, push};
        entry     = {ioctl_addr[22:1], ioctl_data, ioctl_addr[0] ? 2'b01 : 2'b10};
        flushing  = (state == FLUSH) | fall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            count     <= 2'd0;
            dl_prev   <= 1'b0;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= 2'b11;
            prom_we   <= '0;
            prom_addr <= '0;
            prom_data <= '0;
            dl_done   <= 1'b0;
            overflow  <= 1'b0;
            checksum  <= '0;
        end else begin
            dl_prev <= downloading;
            prom_we <= '0;
            dl_done <= 1'b0;

            if (pop)
                fifo_q[0] <= fifo_q[1];
            if (push)
                fifo_q[wr_idx] <= entry;
            count    <= count_nxt;
            overflow <= (overflow & ~rise) | drop;

            if (push | (strobe & in_prom))
                checksum <= (rise ? 16'h0 : checksum) + {8'h00, ioctl_data};
            else if (rise)
                checksum <= '0;

            if (strobe & in_prom) begin
                prom_we   <= PROM_CNT'(1) << (off >> PROM_AW);
                prom_addr <= off[PROM_AW-1:0];
                prom_data <= ioctl_data;
            end

            if (rise) begin
                state   <= IDLE;
                prog_we <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (count != 2'd0) begin
                            {prog_addr, prog_data, prog_mask} <= fifo_q[0];
                            prog_we <= 1'b1;
                            state   <= fall ? FLUSH : ISSUE;
                        end else if (fall) begin
                            dl_done <= 1'b1;
                        end
                    end
                    default: begin
                        // prog_we is always high in ISSUE/FLUSH
                        if (pop && count == 2'd2) begin
                            {prog_addr, prog_data, prog_mask} <= fifo_q[1];
                            state <= flushing ? FLUSH : ISSUE;
                        end else if (pop) begin
                            prog_we <= 1'b0;
                            dl_done <= flushing;
                            state   <= IDLE;
                        end else begin
                            state <= flushing ? FLUSH : ISSUE;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rom_dl_router.sv
// Bench for rom_dl_router: directed scenarios plus randomized download windows, all checked
// against a queue-based model of accepted SDRAM bytes, PROM strobes, checksum and completion.
module tb_rom_dl_router;
    localparam logic [24:0] PS = 25'h3C000;
    localparam logic [24:0] PE = PS + 25'h800;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        downloading = 1'b0, ioctl_wr = 1'b0, prog_ack = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        prog_we, dl_done, overflow;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data, prom_we, prom_addr, prom_data;
    logic [1:0]  prog_mask;
    logic [15:0] checksum;

    rom_dl_router dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_ack(prog_ack), .prom_we(prom_we), .prom_addr(prom_addr),
        .prom_data(prom_data), .dl_done(dl_done), .overflow(overflow), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int          total = 0, bad = 0, acks = 0, dones = 0;
    logic [31:0] q[$];
    logic [15:0] m_sum;
    logic        m_ovf, m_dl, m_flush, exp_done;
    logic [7:0]  exp_pwe, exp_paddr, exp_pdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_sum = '0; m_ovf = 1'b0; m_dl = 1'b0; m_flush = 1'b0;
        exp_done = 1'b0; exp_pwe = '0; exp_paddr = '0; exp_pdata = '0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_prog_we"}, prog_we, 0);
        check({tag, "_prog_addr"}, prog_addr, 0);
        check({tag, "_prog_data"}, prog_data, 0);
        check({tag, "_prog_mask"}, prog_mask, 3);
        check({tag, "_prom_we"}, prom_we, 0);
        check({tag, "_prom_addr"}, prom_addr, 0);
        check({tag, "_prom_data"}, prom_data, 0);
        check({tag, "_dl_done"}, dl_done, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_checksum"}, checksum, 0);
    endtask

    // Drive one cycle's inputs (called at a negedge), advance the model, then check at the next negedge.
    task automatic cycle(input logic dl, input logic wr, input logic [24:0] a,
                         input logic [7:0] d, input logic ack);
        logic        pw, pop, rise, fall;
        int          sz;
        logic [24:0] off;
        logic [7:0]  one8;
        one8 = 8'd1;
        pw = prog_we;
        downloading = dl; ioctl_wr = wr; ioctl_addr = a; ioctl_data = d; prog_ack = ack;
        rise = dl && !m_dl;
        fall = !dl && m_dl;
        pop = pw && ack && !rise;
        exp_pwe = '0; exp_done = 1'b0;
        if (rise) begin
            q.delete(); m_sum = '0; m_ovf = 1'b0; m_flush = 1'b0;
        end
        sz = q.size();
        if (pop) begin
            acks++;
            void'(q.pop_front());
        end
        if (wr && dl) begin
            if (a < PS) begin
                if (sz < 2 || pop) begin
                    q.push_back({a[22:1], d, a[0] ? 2'b01 : 2'b10});
                    m_sum = m_sum + {8'h00, d};
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (a < PE) begin
                off = a - PS;
                exp_pwe = one8 << (off >> 8);
                exp_paddr = off[7:0];
                exp_pdata = d;
                m_sum = m_sum + {8'h00, d};
            end
        end
        if (fall) m_flush = 1'b1;
        if (m_flush && q.size() == 0) begin
            exp_done = 1'b1;
            m_flush = 1'b0;
        end
        m_dl = dl;
        @(negedge clk);
        if (dl_done) dones++;
        check("checksum", checksum, m_sum);
        check("overflow", overflow, m_ovf);
        check("dl_done", dl_done, exp_done);
        check("prom_we", prom_we, exp_pwe);
        if (exp_pwe != 0) begin
            check("prom_addr", prom_addr, exp_paddr);
            check("prom_data", prom_data, exp_pdata);
        end
        if (prog_we) begin
            check("prog_pending", q.size() != 0, 1);
            if (q.size() != 0) check("prog_entry", {prog_addr, prog_data, prog_mask}, q[0]);
        end
    endtask

    task automatic idle(input int n, input logic dl);
        repeat (n) cycle(dl, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wait_we(input int max, input logic dl);
        int k = 0;
        while (!prog_we && k < max) begin
            cycle(dl, 1'b0, '0, '0, 1'b0);
            k++;
        end
        check("wait_prog_we", prog_we, 1);
    endtask

    task automatic new_window();
        int k = 0;
        cycle(1'b0, 1'b0, '0, '0, 1'b0);
        while (m_flush && k < 50) begin
            cycle(1'b0, 1'b0, '0, '0, prog_we);
            k++;
        end
        check("window_drain", m_flush, 0);
        cycle(1'b1, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a0, d0, k, len, ackp;
        logic [24:0] ra;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        // SDRAM byte routing and issue latency
        cycle(1'b1, 1'b0, '0, '0, 1'b0);
        cycle(1'b1, 1'b1, 25'h10, 8'hA5, 1'b0);
        check("latency_push", prog_we, 0);
        idle(1, 1'b1);
        check("latency_issue", prog_we, 1);
        check("t1_addr0", prog_addr, 22'h8);
        check("t1_mask0", prog_mask, 2'b10);
        check("t1_data0", prog_data, 8'hA5);
        idle(2, 1'b1);
        cycle(1'b1, 1'b0, '0, '0, 1'b1);
        cycle(1'b1, 1'b1, 25'h11, 8'h5A, 1'b0);
        idle(1, 1'b1);
        check("t1_addr1", prog_addr, 22'h8);
        check("t1_mask1", prog_mask, 2'b01);
        check("t1_data1", prog_data, 8'h5A);
        idle(2, 1'b1);
        cycle(1'b1, 1'b0, '0, '0, 1'b1);
        idle(1, 1'b1);
        check("t1_checksum", checksum, 16'h00FF);

        // PROM routing
        cycle(1'b1, 1'b1, PS + 25'h205, 8'h3C, 1'b0);
        check("t2_prom_we", prom_we, 8'b0000_0100);
        check("t2_prom_addr", prom_addr, 8'h05);
        check("t2_prom_data", prom_data, 8'h3C);
        check("t2_prog_we", prog_we, 0);

        // Overflow with ack held low
        new_window();
        a0 = acks;
        cycle(1'b1, 1'b1, 25'h100, 8'h11, 1'b0);
        cycle(1'b1, 1'b1, 25'h101, 8'h22, 1'b0);
        cycle(1'b1, 1'b1, 25'h102, 8'h33, 1'b0);
        check("t3_overflow", overflow, 1);
        wait_we(10, 1'b1);
        cycle(1'b1, 1'b0, '0, '0, 1'b1);
        wait_we(10, 1'b1);
        cycle(1'b1, 1'b0, '0, '0, 1'b1);
        idle(3, 1'b1);
        check("t3_writes", acks - a0, 2);
        check("t3_prog_we_idle", prog_we, 0);
        check("t3_checksum", checksum, 16'h0033);

        // Simultaneous push and pop on a full buffer
        new_window();
        a0 = acks;
        cycle(1'b1, 1'b1, 25'h200, 8'h01, 1'b0);
        cycle(1'b1, 1'b1, 25'h201, 8'h02, 1'b0);
        wait_we(10, 1'b1);
        cycle(1'b1, 1'b1, 25'h202, 8'h03, 1'b1);
        check("t4_overflow", overflow, 0);
        k = 0;
        while (acks - a0 < 3 && k < 50) begin
            cycle(1'b1, 1'b0, '0, '0, prog_we);
            k++;
        end
        check("t4_writes", acks - a0, 3);
        check("t4_checksum", checksum, 16'h0006);

        // End of download with two entries pending
        new_window();
        cycle(1'b1, 1'b1, 25'h300, 8'hAA, 1'b0);
        cycle(1'b1, 1'b1, 25'h301, 8'hBB, 1'b0);
        wait_we(10, 1'b1);
        d0 = dones;
        cycle(1'b0, 1'b0, '0, '0, 1'b0);
        idle(1, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        idle(2, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        check("t5_done_after_ack", dl_done, 1);
        idle(4, 1'b0);
        check("t5_done_once", dones - d0, 1);

        // Reset while a request is outstanding, then restart
        cycle(1'b1, 1'b0, '0, '0, 1'b0);
        cycle(1'b1, 1'b1, 25'h400, 8'h77, 1'b0);
        cycle(1'b1, 1'b1, 25'h401, 8'h78, 1'b0);
        cycle(1'b1, 1'b1, 25'h402, 8'h79, 1'b0);
        check("t6_prog_we_before", prog_we, 1);
        rst_n = 1'b0;
        #1;
        check_reset("t6_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(1'b1, 1'b0, '0, '0, 1'b0);
        check("t6_checksum", checksum, 0);
        check("t6_overflow", overflow, 0);
        idle(3, 1'b1);
        check("t6_no_stale_req", prog_we, 0);
        new_window();

        // Randomized download windows
        for (int seg = 0; seg < 20; seg++) begin
            len  = $urandom_range(20, 120);
            ackp = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 5))
                    0, 1, 2: ra = 25'($urandom_range(0, 32'h3BFFF));
                    3:       ra = PS + 25'($urandom_range(0, 32'h7FF));
                    4:       ra = PE + 25'($urandom_range(0, 32'hFFF));
                    default: ra = 25'h1FFFFFF - 25'($urandom_range(0, 3));
                endcase
                cycle(1'b1, 1'($urandom_range(0, 1)), ra, 8'($urandom),
                      prog_we ? ($urandom_range(0, ackp - 1) == 0) : ($urandom_range(0, 7) == 0));
            end
            d0 = dones;
            cycle(1'b0, 1'b0, '0, '0, 1'b0);
            k = 0;
            while (m_flush && k < 100) begin
                cycle(1'b0, 1'($urandom_range(0, 1)), 25'($urandom_range(0, 32'h3BFFF)),
                      8'($urandom), prog_we && ($urandom_range(0, 2) == 0));
                k++;
            end
            check("rand_drain", m_flush, 0);
            idle(2, 1'b0);
            check("rand_done_once", dones - d0, 1);
            cycle(1'b1, 1'b0, '0, '0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
